// File: rtl/push_pop_driver.sv
// Button front end for the occupancy counter: synchronize, debounce and edge-detect
// both buttons, then issue clean push/pop pulses guarded by a shadow occupancy count.

module push_pop_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_req
);
    localparam logic [7:0] DC_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] r_sync;
    logic [7:0] r_dc;
    logic       r_db;
    logic       r_db_q;
    logic       r_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_dc   <= '0;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_db_q <= r_db;
            // Request on press only; release is silent.
            r_req  <= r_db & ~r_db_q;
            if (r_sync[1] == r_db) begin
                r_dc <= '0;
            end else if (r_dc == DC_MAX) begin
                r_db <= ~r_db;
                r_dc <= '0;
            end else begin
                r_dc <= r_dc + 8'd1;
            end
        end
    end

    assign o_req = r_req;
endmodule

module push_pop_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_COUNT       = 5,
    parameter int CNT_W           = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_push,
    input  logic             i_btn_pop,
    output logic             o_push,
    output logic             o_pop,
    output logic [CNT_W-1:0] o_shadow_cnt,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_reject
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    logic [1:0]       w_btn;
    logic [1:0]       w_req;
    logic [CNT_W-1:0] r_cnt;
    logic             r_push;
    logic             r_pop;
    logic             r_reject;
    logic             r_pend;

    assign w_btn = {i_btn_pop, i_btn_push};

    // Lane 0 is push, lane 1 is pop.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        push_pop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_btn   (w_btn[g]),
            .o_req   (w_req[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_reject <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_reject <= 1'b0;
            if (w_req[0]) begin
                if (r_cnt < CNT_MAX) begin
                    r_push <= 1'b1;
                    r_cnt  <= r_cnt + 1'b1;
                end else begin
                    r_reject <= 1'b1;
                end
                // A colliding pop is deferred one slot so pulses never overlap.
                if (w_req[1]) r_pend <= 1'b1;
            end else if (w_req[1] || r_pend) begin
                if (r_cnt != '0) begin
                    r_pop <= 1'b1;
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_reject <= 1'b1;
                end
                r_pend <= 1'b0;
            end
        end
    end

    assign o_push       = r_push;
    assign o_pop        = r_pop;
    assign o_reject     = r_reject;
    assign o_shadow_cnt = r_cnt;
    assign o_full       = (r_cnt == CNT_MAX);
    assign o_empty      = (r_cnt == '0);
endmodule
